// File: rtl/pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// pc_gen_pkg
// Shared types and helpers for the fetch-stage PC generator.
//   pc_src_e     : encoding of the source of the last PC update
//   ALIGN_MASK   : low target bits that must be zero for an aligned fetch
//   is_misaligned: true when the masked low bits of a target are non-zero
// ---------------------------------------------------------------------------
package pc_gen_pkg;

    typedef enum logic [2:0] {
        SRC_INC    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_RET    = 3'd3,
        SRC_HOLD   = 3'd4
    } pc_src_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return ((lsb & ALIGN_MASK) != 2'b00);
    endfunction

endpackage

// File: rtl/pc_gen_ras_if.sv
// ---------------------------------------------------------------------------
// pc_gen_ras_if
// Redirect-request and status bundle between the fetch control logic
// (master) and the PC generator (slave).
//   Requests : stall_i, branch_taken_i/branch_target_i, jump_i/jump_target_i,
//              call_i/link_addr_i, ret_i/ret_target_i
//   Status   : pc_o, pc_src_o, ras_empty_o, ras_full_o, ras_underflow_o,
//              misalign_o
// ---------------------------------------------------------------------------
interface pc_gen_ras_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            branch_taken_i;
    logic [XLEN-1:0] branch_target_i;
    logic            jump_i;
    logic [XLEN-1:0] jump_target_i;
    logic            call_i;
    logic [XLEN-1:0] link_addr_i;
    logic            ret_i;
    logic [XLEN-1:0] ret_target_i;
    logic [XLEN-1:0] pc_o;
    logic [2:0]      pc_src_o;
    logic            ras_empty_o;
    logic            ras_full_o;
    logic            ras_underflow_o;
    logic            misalign_o;

    modport master (
        output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
               call_i, link_addr_i, ret_i, ret_target_i,
        input  pc_o, pc_src_o, ras_empty_o, ras_full_o, ras_underflow_o, misalign_o
    );

    modport slave (
        input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
               call_i, link_addr_i, ret_i, ret_target_i,
        output pc_o, pc_src_o, ras_empty_o, ras_full_o, ras_underflow_o, misalign_o
    );
endinterface

// File: rtl/pc_gen_ras_ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. A push writes at top+1 (wrapping) and, when
// already full, silently overwrites the oldest entry. A pop on an empty stack
// is a no-op; the caller flags the underflow.
//   clk, rst    : clock, synchronous active-low reset (clears count/pointer)
//   push_i      : write push_data_i at top+1 and advance top
//   pop_i       : retreat top (top_data_o is the popped value this cycle)
//   push_data_i : link address to store
//   top_data_o  : entry at the current top
//   count_o     : number of valid entries
//   empty_o     : registered, count==0
//   full_o      : registered, count==RAS_DEPTH
// ---------------------------------------------------------------------------
module ras_stack #(
    parameter  int RAS_DEPTH = 4,
    parameter  int XLEN      = 32,
    localparam int PW        = $clog2(RAS_DEPTH),
    localparam int CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_data_o,
    output logic [CW-1:0]   count_o,
    output logic            empty_o,
    output logic            full_o
);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d;
    logic [PW-1:0]   top_inc_s, top_dec_s;
    logic [CW-1:0]   count_q, count_d;
    logic            empty_q, full_q;

    // Wrapping pointer arithmetic and next pointer/count selection.
    always_comb begin
        top_inc_s = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + PW'(1'b1);
        top_dec_s = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - PW'(1'b1);
        top_d     = top_q;
        count_d   = count_q;
        if (push_i) begin
            top_d = top_inc_s;
            if (count_q != CW'(RAS_DEPTH)) begin
                count_d = count_q + CW'(1'b1);
            end else begin
                count_d = count_q;
            end
        end else if (pop_i && (count_q != '0)) begin
            top_d   = top_dec_s;
            count_d = count_q - CW'(1'b1);
        end else begin
            top_d   = top_q;
            count_d = count_q;
        end
    end

    // Pointer, occupancy and registered empty/full flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            top_q   <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(RAS_DEPTH));
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (rst && push_i) begin
            mem_q[top_inc_s] <= push_data_i;
        end
    end

    assign top_data_o = mem_q[top_q];
    assign count_o    = count_q;
    assign empty_o    = empty_q;
    assign full_o     = full_q;

endmodule

// File: rtl/pc_gen_ras.sv
// ---------------------------------------------------------------------------
// pc_gen_ras
// Fetch-stage program-counter generator with fixed redirect priority
// (branch > jump > return > stall > increment) and an optional return-address
// stack. Redirect targets are forced to alignment and misalignment is flagged.
// All outputs are registered; one cycle latency from request to pc_o.
//   clk, rst : clock, synchronous active-low reset
//   bus      : pc_gen_ras_if slave (requests in, PC and status out)
// Build option: define PC_RAS_EN to build the return-address stack; without
// it ret_i always uses ret_target_i and the RAS status outputs are constant.
// ---------------------------------------------------------------------------
module pc_gen_ras
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] INC       = XLEN'(32'd4),
    parameter int              RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    pc_gen_ras_if.slave   bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    pc_src_e         src_q, src_d;
    logic            misalign_q, misalign_d;
    logic            underflow_q, underflow_d;
    logic [XLEN-1:0] tgt_s;
    logic            redirect_s;
    logic            push_s, pop_s;
    logic [XLEN-1:0] ras_top_s;
    logic            ras_empty_s, ras_full_s;

`ifdef PC_RAS_EN
    localparam logic RAS_EN = 1'b1;
    logic [$clog2(RAS_DEPTH+1)-1:0] ras_count_unused_s;

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .push_data_i (bus.link_addr_i),
        .top_data_o  (ras_top_s),
        .count_o     (ras_count_unused_s),
        .empty_o     (ras_empty_s),
        .full_o      (ras_full_s)
    );
`else
    localparam logic RAS_EN = 1'b0;
    logic unused_ras_s;

    assign ras_top_s    = '0;
    assign ras_empty_s  = 1'b1;
    assign ras_full_s   = 1'b0;
    assign unused_ras_s = ^{push_s, pop_s, bus.link_addr_i};
`endif

    // Next-PC selection; only the winning arm may push or pop the RAS.
    always_comb begin
        pc_d        = pc_q;
        src_d       = SRC_HOLD;
        tgt_s       = '0;
        redirect_s  = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        underflow_d = 1'b0;
        misalign_d  = 1'b0;
        if (bus.branch_taken_i) begin
            tgt_s      = bus.branch_target_i;
            src_d      = SRC_BRANCH;
            redirect_s = 1'b1;
        end else if (bus.jump_i) begin
            tgt_s      = bus.jump_target_i;
            src_d      = SRC_JUMP;
            redirect_s = 1'b1;
            push_s     = bus.call_i;
        end else if (bus.ret_i) begin
            src_d      = SRC_RET;
            redirect_s = 1'b1;
            pop_s      = 1'b1;
            if (!ras_empty_s) begin
                tgt_s = ras_top_s;
            end else begin
                tgt_s       = bus.ret_target_i;
                underflow_d = RAS_EN;
            end
        end else if (bus.stall_i) begin
            pc_d  = pc_q;
            src_d = SRC_HOLD;
        end else begin
            pc_d  = pc_q + INC;
            src_d = SRC_INC;
        end

        if (redirect_s) begin
            pc_d       = tgt_s & ~XLEN'(ALIGN_MASK);
            misalign_d = is_misaligned(tgt_s[1:0]);
        end else begin
            misalign_d = 1'b0;
        end
    end

    // Architectural PC and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_VEC;
            src_q       <= SRC_HOLD;
            misalign_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            src_q       <= src_d;
            misalign_q  <= misalign_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.pc_o            = pc_q;
    assign bus.pc_src_o        = src_q;
    assign bus.misalign_o      = misalign_q;
    assign bus.ras_underflow_o = underflow_q;
    assign bus.ras_empty_o     = ras_empty_s;
    assign bus.ras_full_o      = ras_full_s;

endmodule

// File: tb/tb_pc_gen_ras.sv
// ---------------------------------------------------------------------------
// tb_pc_gen_ras
// Scoreboard bench for pc_gen_ras: every driven cycle pushes the reference
// model's expected outputs; each test task pops and compares after the edge.
// The reference RAS is a queue (push_back/pop_back, drop oldest when full).
// ---------------------------------------------------------------------------
module tb_pc_gen_ras;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [38:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    exp_t            sb[$];
    exp_t            exp_e;
    logic [38:0]     obs;
    logic [31:0]     m_pc;
    logic [31:0]     m_stk[$];

    pc_gen_ras_if #(.XLEN(XLEN)) ifc ();

    pc_gen_ras #(
        .XLEN      (XLEN),
        .RESET_VEC (32'h0),
        .INC       (32'd4),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        ifc.stall_i         = 1'b0;
        ifc.branch_taken_i  = 1'b0;
        ifc.branch_target_i = 32'h0;
        ifc.jump_i          = 1'b0;
        ifc.jump_target_i   = 32'h0;
        ifc.call_i          = 1'b0;
        ifc.link_addr_i     = 32'h0;
        ifc.ret_i           = 1'b0;
        ifc.ret_target_i    = 32'h0;
    endtask

    // Model the current inputs, queue the expectation, then advance one edge.
    task automatic drive_cycle(input string name);
        logic [31:0] tgt;
        logic [2:0]  src;
        bit          redir, uf, mis, emp, ful;
        exp_t        e;
        tgt = 32'h0; src = 3'd4; redir = 1'b0; uf = 1'b0; mis = 1'b0;
        if (!rst) begin
            m_pc = 32'h0;
            m_stk.delete();
        end else if (ifc.branch_taken_i) begin
            tgt = ifc.branch_target_i; src = 3'd1; redir = 1'b1;
        end else if (ifc.jump_i) begin
            tgt = ifc.jump_target_i; src = 3'd2; redir = 1'b1;
            if (RAS_ON && ifc.call_i) begin
                if (m_stk.size() == DEPTH) void'(m_stk.pop_front());
                m_stk.push_back(ifc.link_addr_i);
            end
        end else if (ifc.ret_i) begin
            src = 3'd3; redir = 1'b1;
            if (RAS_ON && m_stk.size() > 0) begin
                tgt = m_stk.pop_back();
            end else begin
                tgt = ifc.ret_target_i;
                uf  = RAS_ON;
            end
        end else if (ifc.stall_i) begin
            src = 3'd4;
        end else begin
            m_pc = m_pc + 32'd4;
            src  = 3'd0;
        end
        if (redir) begin
            m_pc = {tgt[31:2], 2'b00};
            mis  = (tgt[1:0] != 2'b00);
        end
        emp    = RAS_ON ? (m_stk.size() == 0) : 1'b1;
        ful    = RAS_ON ? (m_stk.size() == DEPTH) : 1'b0;
        e.name = name;
        e.val  = {m_pc, src, emp, ful, uf, mis};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        drive_cycle("reset");
        exp_e = sb.pop_front();
        obs = {ifc.pc_o, ifc.pc_src_o, ifc.ras_empty_o, ifc.ras_full_o, ifc.ras_underflow_o, ifc.misalign_o};
        checks++;
        if (obs !== exp_e.val) begin
            errors++;
            $display("FAIL %s: got %h want %h (pc,src,empty,full,uf,mis)", exp_e.name, obs, exp_e.val);
        end
        checks++;
        if (ifc.pc_o !== 32'h0 || ifc.pc_src_o !== 3'd4 || ifc.ras_empty_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_const: got pc=%h src=%0d empty=%b want pc=0 src=4 empty=1",
                     ifc.pc_o, ifc.pc_src_o, ifc.ras_empty_o);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle($sformatf("inc%0d", i));
            exp_e = sb.pop_front();
            obs = {ifc.pc_o, ifc.pc_src_o, ifc.ras_empty_o, ifc.ras_full_o, ifc.ras_underflow_o, ifc.misalign_o};
            checks++;
            if (obs !== exp_e.val) begin
                errors++;
                $display("FAIL %s: got %h want %h (pc,src,empty,full,uf,mis)", exp_e.name, obs, exp_e.val);
            end
        end
        checks++;
        if (ifc.pc_o !== 32'hC || ifc.pc_src_o !== 3'd0) begin
            errors++;
            $display("FAIL inc_const: got pc=%h src=%0d want pc=c src=0", ifc.pc_o, ifc.pc_src_o);
        end
    endtask

    task automatic test_stall_redirect();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            ifc.stall_i = 1'b1;
            if (i == 0) begin
                ifc.branch_taken_i = 1'b1; ifc.branch_target_i = 32'h100;
            end else if (i == 2) begin
                ifc.jump_i = 1'b1; ifc.jump_target_i = 32'h180;
            end
            drive_cycle($sformatf("stall%0d", i));
            exp_e = sb.pop_front();
            obs = {ifc.pc_o, ifc.pc_src_o, ifc.ras_empty_o, ifc.ras_full_o, ifc.ras_underflow_o, ifc.misalign_o};
            checks++;
            if (obs !== exp_e.val) begin
                errors++;
                $display("FAIL %s: got %h want %h (pc,src,empty,full,uf,mis)", exp_e.name, obs, exp_e.val);
            end
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            case (i)
                0: begin
                    ifc.branch_taken_i = 1'b1; ifc.branch_target_i = 32'h200;
                    ifc.jump_i = 1'b1; ifc.call_i = 1'b1;
                    ifc.jump_target_i = 32'h300; ifc.link_addr_i = 32'h304;
                end
                1: begin
                    ifc.call_i = 1'b1; ifc.link_addr_i = 32'h500;
                end
                2: begin
                    ifc.jump_i = 1'b1; ifc.jump_target_i = 32'h600;
                    ifc.ret_i = 1'b1; ifc.ret_target_i = 32'h700;
                end
                default: begin
                    ifc.ret_i = 1'b1; ifc.ret_target_i = 32'h44;
                end
            endcase
            drive_cycle($sformatf("prio%0d", i));
            exp_e = sb.pop_front();
            obs = {ifc.pc_o, ifc.pc_src_o, ifc.ras_empty_o, ifc.ras_full_o, ifc.ras_underflow_o, ifc.misalign_o};
            checks++;
            if (obs !== exp_e.val) begin
                errors++;
                $display("FAIL %s: got %h want %h (pc,src,empty,full,uf,mis)", exp_e.name, obs, exp_e.val);
            end
        end
    endtask

    task automatic test_ras_overflow();
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            if (i < 5) begin
                ifc.jump_i = 1'b1; ifc.call_i = 1'b1;
                ifc.jump_target_i = 32'h1000 + 32'(i) * 32'h100;
                ifc.link_addr_i   = 32'h10 * 32'(i + 1);
            end else begin
                ifc.ret_i = 1'b1; ifc.ret_target_i = 32'h999;
            end
            drive_cycle($sformatf("ras%0d", i));
            exp_e = sb.pop_front();
            obs = {ifc.pc_o, ifc.pc_src_o, ifc.ras_empty_o, ifc.ras_full_o, ifc.ras_underflow_o, ifc.misalign_o};
            checks++;
            if (obs !== exp_e.val) begin
                errors++;
                $display("FAIL %s: got %h want %h (pc,src,empty,full,uf,mis)", exp_e.name, obs, exp_e.val);
            end
        end
        checks++;
        if (ifc.pc_o !== 32'h998 || ifc.misalign_o !== 1'b1 || ifc.ras_underflow_o !== RAS_ON) begin
            errors++;
            $display("FAIL ras_last_ret: got pc=%h mis=%b uf=%b want pc=998 mis=1 uf=%b",
                     ifc.pc_o, ifc.misalign_o, ifc.ras_underflow_o, RAS_ON);
        end
    endtask

    task automatic test_misalign();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (i == 0) begin
                ifc.jump_i = 1'b1; ifc.jump_target_i = 32'h1002;
            end else if (i == 2) begin
                ifc.branch_taken_i = 1'b1; ifc.branch_target_i = 32'h2001;
            end
            drive_cycle($sformatf("mis%0d", i));
            exp_e = sb.pop_front();
            obs = {ifc.pc_o, ifc.pc_src_o, ifc.ras_empty_o, ifc.ras_full_o, ifc.ras_underflow_o, ifc.misalign_o};
            checks++;
            if (obs !== exp_e.val) begin
                errors++;
                $display("FAIL %s: got %h want %h (pc,src,empty,full,uf,mis)", exp_e.name, obs, exp_e.val);
            end
        end
    endtask

    task automatic test_wrap_and_reset_mid();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            rst = 1'b1;
            case (i)
                0: begin ifc.jump_i = 1'b1; ifc.jump_target_i = 32'hFFFF_FFFC; end
                1: ;
                2, 3: begin
                    ifc.jump_i = 1'b1; ifc.call_i = 1'b1;
                    ifc.jump_target_i = 32'h40; ifc.link_addr_i = 32'hA0 + 32'(i);
                end
                4: rst = 1'b0;
                default: begin ifc.ret_i = 1'b1; ifc.ret_target_i = 32'h80; end
            endcase
            drive_cycle($sformatf("wrap_rst%0d", i));
            exp_e = sb.pop_front();
            obs = {ifc.pc_o, ifc.pc_src_o, ifc.ras_empty_o, ifc.ras_full_o, ifc.ras_underflow_o, ifc.misalign_o};
            checks++;
            if (obs !== exp_e.val) begin
                errors++;
                $display("FAIL %s: got %h want %h (pc,src,empty,full,uf,mis)", exp_e.name, obs, exp_e.val);
            end
            if (i == 1) begin
                checks++;
                if (ifc.pc_o !== 32'h0) begin
                    errors++;
                    $display("FAIL wrap_const: got pc=%h want pc=0", ifc.pc_o);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            idle_inputs();
            rst                 = 1'b1;
            ifc.stall_i         = ($urandom_range(0, 3) == 0);
            ifc.branch_taken_i  = ($urandom_range(0, 7) == 0);
            ifc.branch_target_i = $urandom & 32'h0000_FFFF;
            ifc.jump_i          = ($urandom_range(0, 3) == 0);
            ifc.jump_target_i   = $urandom & 32'h0000_FFFF;
            ifc.call_i          = ($urandom_range(0, 1) == 0);
            ifc.link_addr_i     = $urandom & 32'h0000_FFFC;
            ifc.ret_i           = ($urandom_range(0, 3) == 0);
            ifc.ret_target_i    = $urandom & 32'h0000_FFFF;
            drive_cycle($sformatf("b2b%0d", i));
            exp_e = sb.pop_front();
            obs = {ifc.pc_o, ifc.pc_src_o, ifc.ras_empty_o, ifc.ras_full_o, ifc.ras_underflow_o, ifc.misalign_o};
            checks++;
            if (obs !== exp_e.val) begin
                errors++;
                $display("FAIL %s: got %h want %h (pc,src,empty,full,uf,mis)", exp_e.name, obs, exp_e.val);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_pc   = 32'h0;
        rst    = 1'b0;
        idle_inputs();
        test_reset();
        test_stall_redirect();
        test_priority();
        test_ras_overflow();
        test_misalign();
        test_wrap_and_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
Parametrised program-counter generator for the fetch stage. It holds the architectural fetch PC and selects the next PC from sequential increment, taken branch, jump or return. A small circular return-address stack (RAS) predicts return targets. Redirect priority is fixed, stalls are explicit, and target misalignment is reported.

Parameters:
XLEN, 32, PC/address width in bits
RESET_VEC, 0, value loaded into pc_o on reset
INC, 4, sequential increment added to pc_o
RAS_DEPTH, 4, return-address stack entries (>=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
stall_i  in  1  hold PC when no redirect is present
branch_taken_i  in  1  taken-branch redirect request
branch_target_i  in  XLEN  branch target
jump_i  in  1  unconditional jump redirect request
jump_target_i  in  XLEN  jump target
call_i  in  1  qualifies jump_i as a call (push link address)
link_addr_i  in  XLEN  return address pushed on a call
ret_i  in  1  return redirect request (pop RAS)
ret_target_i  in  XLEN  computed return target; used when RAS is empty
pc_o  out  XLEN  current fetch PC (registered)
pc_src_o  out  3  source of the last pc_o update (see package enum)
ras_empty_o  out  1  RAS holds 0 valid entries
ras_full_o  out  1  RAS holds RAS_DEPTH valid entries
ras_underflow_o  out  1  one-cycle pulse: ret_i taken with empty RAS
misalign_o  out  1  one-cycle pulse: redirect target had bits[1:0] != 0

Behaviour:
- Reset (rst==0 at clk edge): pc_o=RESET_VEC; pc_src_o=SRC_HOLD; RAS count=0 and top pointer=0; ras_empty_o=1; ras_full_o=0; ras_underflow_o=0; misalign_o=0. A reset mid-operation discards all RAS contents.
- Next-PC priority, evaluated each edge with rst==1, first match wins:
  - branch_taken_i: pc_o=branch_target_i, SRC_BRANCH
  - jump_i: pc_o=jump_target_i, SRC_JUMP
  - ret_i: pc_o=RAS top if non-empty, else ret_target_i; SRC_RET
  - stall_i: pc_o unchanged, SRC_HOLD
  - otherwise: pc_o=pc_o+INC (mod 2^XLEN, wraps silently), SRC_INC
- Redirects override stall_i. A redirect is never dropped.
- Latency: one cycle. Inputs at edge N are reflected in pc_o after edge N.
- Misalignment: on any redirect whose target has bits[1:0]!=0, pc_o loads the target with bits[1:0] cleared and misalign_o=1 for exactly that cycle. Otherwise misalign_o=0.
- RAS push: only when the jump arm wins and call_i=1. The stack writes link_addr_i at top+1 (mod RAS_DEPTH).
  - If not full, count increments.
  - If full, the oldest entry is overwritten and count stays at RAS_DEPTH.
- RAS pop: only when the ret arm wins.
  - If count>0: the stack returns the entry at top, then top decrements (mod) and count decrements.
  - If count==0: count stays 0 and ras_underflow_o=1 for that cycle.
- A losing arm has no side effects. Examples: call with branch_taken_i gives no push; ret with jump_i gives no pop.
- Push and pop cannot occur in the same cycle; the priority order enforces this.
- call_i without jump_i is ignored.
- ras_empty_o and ras_full_o are registered and reflect count after the edge.

Optional Feature:
- Macro PC_RAS_EN.
- When defined: RAS behaves as described above.
- When undefined: no RAS storage is built. ret_i always redirects to ret_target_i. ras_empty_o=1, ras_full_o=0 and ras_underflow_o=0 constantly. call_i is ignored.

Decomposition:
- Package pc_gen_pkg holds:
  - pc_src_e, 3-bit enum: SRC_INC=0, SRC_BRANCH=1, SRC_JUMP=2, SRC_RET=3, SRC_HOLD=4
  - ALIGN_MASK constant for bits[1:0]
- One natural sub-module: ras_stack (parameters RAS_DEPTH and XLEN). Ports: push, pop, push_data, top_data, count, empty, full.
- pc_gen_ras instantiates ras_stack under PC_RAS_EN.

Test Plan:
- Reset release, 3 idle cycles -> pc_o steps 0x0, 0x4, 0x8, 0xC; pc_src_o=SRC_INC.
- stall_i=1 together with branch_taken_i=1, branch_target_i=0x100 -> pc_o=0x100, SRC_BRANCH. Next cycle stall_i=1 alone -> pc_o holds 0x100, SRC_HOLD.
- branch_taken_i and jump_i+call_i in the same cycle (targets 0x200, 0x300) -> pc_o=0x200 and RAS count remains 0.
- With RAS_DEPTH=4: 5 calls with link 0x10, 0x20, 0x30, 0x40, 0x50, then 5 returns -> returns yield 0x50, 0x40, 0x30, 0x20. The fifth return uses ret_target_i=0x999 (loads 0x998, misalign_o=1) and ras_underflow_o=1.
- jump_i with target 0x1002 -> pc_o=0x1000, misalign_o high for exactly one cycle.
- pc_o=0xFFFFFFFC, idle -> pc_o=0x0 (wrap). rst=0 after 2 pushes, then rst=1 and ret_i with ret_target_i=0x80 -> pc_o=0x80, ras_underflow_o=1.
